glitch_cmd_loader: RTL and testbench
====================================

Name: glitch_cmd_loader

Overview:
- Upstream front-end for the glitch core; sits between the host byte stream (UART receiver) and the core's serial configuration port.
- Parses host commands, collects the delay word, width word and polarity, and serially shifts them into the core over enable/t_data.
- Waits for armed, then drives go on a fire command and returns a one-byte status per command.

Parameters:
- CNT_W, 64, width of each core counter word in bits; must be a multiple of 8.
- ARM_TIMEOUT, 256, cycles to wait for core_armed after the last shifted bit.
- DONE_TIMEOUT, 65535, cycles to wait for core_done after go asserts.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- in_data  in  8  host command/argument byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  loader accepts byte when in_valid&in_ready.
- resp_data  out  8  status byte.
- resp_valid  out  1  status valid; held until resp_ready.
- resp_ready  in  1  host consumes status.
- core_enable  out  1  core enable; low acts as core pseudo-reset.
- core_tdata  out  1  serial config bit to core.
- core_go  out  1  fire request to core.
- core_armed  in  1  core reports both words loaded.
- core_done  in  1  core reports glitch sequence complete.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: core_enable=0, core_tdata=0, core_go=0, resp_valid=0, resp_data=0, in_ready=0, busy=0; FSM→IDLE; arg buffer cleared. Reset mid-shift or mid-fire aborts with no response.
- Opcodes: 0x01 LOAD, followed by CNT_W/8 delay bytes, CNT_W/8 width bytes and 1 polarity byte (bit0 used), all MSB byte first. 0x02 FIRE, no args. 0x03 CLEAR, no args.
- Status codes: 0xA0 load ok, 0xA1 fire done, 0xA2 clear ok, 0xE0 bad opcode, 0xE1 arm timeout, 0xE2 done timeout, 0xE3 fire while not armed.
- in_ready=1 only in IDLE and RX_ARGS; 0 everywhere else, including RESP.
- States:
  - IDLE: accepting a byte decodes the opcode. 0x01→RX_ARGS with byte count=2*CNT_W/8+1. 0x02→FIRE if core_armed=1, else RESP(0xE3). 0x03→CLR. Any other value→RESP(0xE0).
  - RX_ARGS: each accepted byte shifts into the arg buffer; after the final byte→CLR_LOAD.
  - CLR / CLR_LOAD: core_enable=0 and core_tdata=0 for exactly 2 cycles. Then CLR→RESP(0xA2); CLR_LOAD→SHIFT.
  - SHIFT: core_enable=1 on the first SHIFT cycle and stays 1 until the next CLR*. Bit k (k=0..2*CNT_W-1) drives core_tdata in SHIFT cycle k, order delay MSB..LSB then width MSB..LSB. After the last bit→WAIT_ARM, with core_tdata=polarity.
  - Polarity: core_tdata holds the polarity value from then on, until the next CLR*.
  - WAIT_ARM: core_armed=1→RESP(0xA0). ARM_TIMEOUT cycles elapsed→RESP(0xE1); core_enable stays 1.
  - FIRE: core_go=1 from the cycle after FIRE is accepted, held high while waiting. core_done=1 → core_go=0 the next cycle, →RESP(0xA1). DONE_TIMEOUT cycles elapsed → core_go=0, →RESP(0xE2).
  - RESP: resp_valid=1 with the code; on resp_valid&resp_ready→IDLE. resp_data is stable while resp_valid.
- core_done already high on FIRE entry counts as done on the first FIRE cycle.
- Counters saturate at their limits and never wrap. Timeout compare is ≥ limit.

Decomposition:
- Shared package glitch_pkg: opcode constants, status code constants, FSM state enum.
- One sub-module: glitch_piso, a CNT_W*2-bit parallel-load, MSB-first shift register with load/shift/last outputs, used in SHIFT.

Test Plan:
- LOAD, CNT_W=16: bytes 01 12 34 00 05 00; core model asserts armed after the 32nd bit. Required: enable low 2 cycles, then t_data serial 0x1234 then 0x0005 MSB-first, t_data=0 after; resp 0xA0; in_ready=0 during SHIFT.
- LOAD with polarity byte 0x01 → t_data=1 held after the last bit through ≥100 cycles; resp 0xA0.
- FIRE after a good load; core model raises done 20 cycles after go → go high exactly 20 cycles plus 1, then low; resp 0xA1.
- FIRE with core_armed=0 → resp 0xE3, go never asserts. Opcode 0x7F → resp 0xE0.
- Arm timeout, ARM_TIMEOUT=8: armed held low → resp 0xE1 exactly 8 cycles after the last bit. Done timeout, DONE_TIMEOUT=10 → go high 10 cycles, resp 0xE2.
- rst asserted mid-SHIFT (bit 10) → next cycle all outputs at reset values, busy=0; subsequent CLEAR (0x03) → 2-cycle enable low, resp 0xA2; resp_ready held low 5 cycles keeps resp_valid and 0xA2 stable.

Source files
------------

// File: rtl/glitch_pkg.sv
// Shared definitions for the glitch command loader: host opcodes, status bytes and FSM states.
package glitch_pkg;

    localparam logic [7:0] OpLoad  = 8'h01;
    localparam logic [7:0] OpFire  = 8'h02;
    localparam logic [7:0] OpClear = 8'h03;

    localparam logic [7:0] StsLoadOk    = 8'hA0;
    localparam logic [7:0] StsFireDone  = 8'hA1;
    localparam logic [7:0] StsClearOk   = 8'hA2;
    localparam logic [7:0] StsBadOp     = 8'hE0;
    localparam logic [7:0] StsArmTmo    = 8'hE1;
    localparam logic [7:0] StsDoneTmo   = 8'hE2;
    localparam logic [7:0] StsNotArmed  = 8'hE3;

    typedef enum logic [2:0] {
        StIdle,
        StRxArgs,
        StClr,
        StClrLoad,
        StShift,
        StWaitArm,
        StFire,
        StResp
    } state_e;

endpackage

// File: rtl/glitch_piso.sv
// Parallel-load, MSB-first shift register feeding the core's serial config input.
module glitch_piso #(
    parameter int unsigned Width = 128
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [Width-1:0] din_i,
    output logic             dout_o,
    output logic             last_o
);

    localparam int unsigned CntW = $clog2(Width);
    localparam logic [CntW-1:0] LastIdx = CntW'(Width - 1);

    logic [Width-1:0] sr_q, sr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (load_i) begin
            sr_d  = din_i;
            cnt_d = '0;
        end else if (shift_i) begin
            sr_d = {sr_q[Width-2:0], 1'b0};
            // Bit index saturates on the last bit so 'last' stays valid.
            if (cnt_q != LastIdx) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

    assign dout_o = sr_q[Width-1];
    assign last_o = (cnt_q == LastIdx);

endmodule

// File: rtl/glitch_cmd_loader.sv
// Host command front-end: parses LOAD/FIRE/CLEAR bytes, shifts config into the glitch core,
// handles arm/fire handshakes and returns one status byte per command.
module glitch_cmd_loader
    import glitch_pkg::*;
#(
    parameter int unsigned CNT_W        = 64,
    parameter int unsigned ARM_TIMEOUT  = 256,
    parameter int unsigned DONE_TIMEOUT = 65535
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] resp_data,
    output logic       resp_valid,
    input  logic       resp_ready,
    output logic       core_enable,
    output logic       core_tdata,
    output logic       core_go,
    input  logic       core_armed,
    input  logic       core_done,
    output logic       busy
);

    localparam int unsigned NumArgs = 2 * CNT_W / 8 + 1;
    localparam int unsigned WordsW  = 2 * CNT_W;
    localparam int unsigned RxCntW  = $clog2(NumArgs + 1);
    localparam int unsigned TmoMax  = (ARM_TIMEOUT > DONE_TIMEOUT) ? ARM_TIMEOUT : DONE_TIMEOUT;
    localparam int unsigned TmoW    = $clog2(TmoMax + 1);

    localparam logic [TmoW-1:0]   ArmLim  = TmoW'(ARM_TIMEOUT);
    localparam logic [TmoW-1:0]   DoneLim = TmoW'(DONE_TIMEOUT);
    localparam logic [TmoW-1:0]   TmoSat  = TmoW'(TmoMax);
    localparam logic [RxCntW-1:0] RxInit  = RxCntW'(NumArgs);

    state_e              state_q, state_d;
    logic [RxCntW-1:0]   rx_cnt_q, rx_cnt_d;
    logic [WordsW-1:0]   arg_q, arg_d;
    logic                arg_pol_q, arg_pol_d;
    logic                clr_q, clr_d;
    logic [TmoW-1:0]     tmo_q, tmo_d;
    logic                en_q, en_d;
    logic                pol_q, pol_d;
    logic [7:0]          resp_q, resp_d;
    logic                in_ready_q, in_ready_d;

    logic accept;
    logic piso_load, piso_shift, piso_dout, piso_last;

    assign accept = in_valid & in_ready_q;

    glitch_piso #(
        .Width (WordsW)
    ) u_piso (
        .clk_i   (clk),
        .rst_i   (rst),
        .load_i  (piso_load),
        .shift_i (piso_shift),
        .din_i   (arg_q),
        .dout_o  (piso_dout),
        .last_o  (piso_last)
    );

    // Next-state and command decode.
    always_comb begin
        state_d    = state_q;
        rx_cnt_d   = rx_cnt_q;
        arg_d      = arg_q;
        arg_pol_d  = arg_pol_q;
        clr_d      = 1'b0;
        resp_d     = resp_q;
        piso_load  = 1'b0;
        piso_shift = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    case (in_data)
                        OpLoad: begin
                            state_d  = StRxArgs;
                            rx_cnt_d = RxInit;
                        end
                        OpFire: begin
                            if (core_armed) begin
                                state_d = StFire;
                            end else begin
                                state_d = StResp;
                                resp_d  = StsNotArmed;
                            end
                        end
                        OpClear: state_d = StClr;
                        default: begin
                            state_d = StResp;
                            resp_d  = StsBadOp;
                        end
                    endcase
                end
            end
            StRxArgs: begin
                if (accept) begin
                    rx_cnt_d = rx_cnt_q - 1'b1;
                    // The final byte carries only polarity; the words stay MSB-aligned.
                    if (rx_cnt_q == RxCntW'(1)) begin
                        arg_pol_d = in_data[0];
                        state_d   = StClrLoad;
                    end else begin
                        arg_d = {arg_q[WordsW-9:0], in_data};
                    end
                end
            end
            StClr, StClrLoad: begin
                clr_d = ~clr_q;
                if (clr_q) begin
                    if (state_q == StClr) begin
                        state_d = StResp;
                        resp_d  = StsClearOk;
                    end else begin
                        state_d   = StShift;
                        piso_load = 1'b1;
                    end
                end
            end
            StShift: begin
                piso_shift = 1'b1;
                if (piso_last) begin
                    state_d = StWaitArm;
                end
            end
            StWaitArm: begin
                if (core_armed) begin
                    state_d = StResp;
                    resp_d  = StsLoadOk;
                end else if (tmo_q >= ArmLim) begin
                    state_d = StResp;
                    resp_d  = StsArmTmo;
                end
            end
            StFire: begin
                if (core_done) begin
                    state_d = StResp;
                    resp_d  = StsFireDone;
                end else if (tmo_q >= DoneLim) begin
                    state_d = StResp;
                    resp_d  = StsDoneTmo;
                end
            end
            StResp: begin
                if (resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Registered core-side controls and the wait counter, all keyed off the next state.
    always_comb begin
        en_d  = en_q;
        pol_d = pol_q;
        if (state_d == StClr || state_d == StClrLoad) begin
            en_d  = 1'b0;
            pol_d = 1'b0;
        end else if (state_d == StShift) begin
            en_d  = 1'b1;
            pol_d = arg_pol_q;
        end

        // Counts cycles spent in the current state, starting at 1 on entry.
        tmo_d = tmo_q;
        if (state_d != state_q) begin
            tmo_d = TmoW'(1);
        end else if (tmo_q != TmoSat) begin
            tmo_d = tmo_q + 1'b1;
        end

        in_ready_d = (state_d == StIdle) || (state_d == StRxArgs);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            rx_cnt_q   <= '0;
            arg_q      <= '0;
            arg_pol_q  <= 1'b0;
            clr_q      <= 1'b0;
            tmo_q      <= '0;
            en_q       <= 1'b0;
            pol_q      <= 1'b0;
            resp_q     <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rx_cnt_q   <= rx_cnt_d;
            arg_q      <= arg_d;
            arg_pol_q  <= arg_pol_d;
            clr_q      <= clr_d;
            tmo_q      <= tmo_d;
            en_q       <= en_d;
            pol_q      <= pol_d;
            resp_q     <= resp_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign resp_valid  = (state_q == StResp);
    assign resp_data   = resp_q;
    assign core_enable = en_q;
    assign core_tdata  = (state_q == StShift) ? piso_dout : pol_q;
    assign core_go     = (state_q == StFire);
    assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_glitch_cmd_loader.sv
// Directed bench for glitch_cmd_loader; a second instance with a short done timeout shares
// all inputs so the fire-complete and fire-timeout paths are exercised by one FIRE command.
module tb_glitch_cmd_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       resp_ready;
    logic       core_armed;
    logic       core_done;

    logic       in_ready_a, resp_valid_a, core_enable_a, core_tdata_a, core_go_a, busy_a;
    logic [7:0] resp_data_a;
    logic       in_ready_b, resp_valid_b, core_enable_b, core_tdata_b, core_go_b, busy_b;
    logic [7:0] resp_data_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    glitch_cmd_loader #(
        .CNT_W        (16),
        .ARM_TIMEOUT  (8),
        .DONE_TIMEOUT (64)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready_a),
        .resp_data   (resp_data_a),
        .resp_valid  (resp_valid_a),
        .resp_ready  (resp_ready),
        .core_enable (core_enable_a),
        .core_tdata  (core_tdata_a),
        .core_go     (core_go_a),
        .core_armed  (core_armed),
        .core_done   (core_done),
        .busy        (busy_a)
    );

    glitch_cmd_loader #(
        .CNT_W        (16),
        .ARM_TIMEOUT  (8),
        .DONE_TIMEOUT (10)
    ) u_dut_dt (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready_b),
        .resp_data   (resp_data_b),
        .resp_valid  (resp_valid_b),
        .resp_ready  (resp_ready),
        .core_enable (core_enable_b),
        .core_tdata  (core_tdata_b),
        .core_go     (core_go_b),
        .core_armed  (core_armed),
        .core_done   (core_done),
        .busy        (busy_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (in_ready_a !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("in_ready wait", 32'(in_ready_a), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_resp(input logic [7:0] exp, input string tag);
        int n;
        n = 0;
        while (resp_valid_a !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " valid"}, 32'(resp_valid_a), 32'd1);
        chk({tag, " code"}, 32'(resp_data_a), 32'(exp));
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk({tag, " back to idle"}, 32'({resp_valid_a, busy_a}), 32'd0);
    endtask

    // Sends a LOAD, checks the 2-cycle clear and collects the serial bits; optionally pulses
    // reset in shift cycle rst_at and returns right after that reset edge.
    task automatic do_load(input logic [15:0] dly, input logic [15:0] wid, input logic [7:0] pol,
                           input int rst_at, output logic [31:0] bits);
        logic [7:0] seq [6];
        logic clr_ok, shift_ok;
        seq = '{8'h01, dly[15:8], dly[7:0], wid[15:8], wid[7:0], pol};
        for (int i = 0; i < 6; i++) send_byte(seq[i]);
        clr_ok = (core_enable_a === 1'b0 && core_tdata_a === 1'b0 && busy_a === 1'b1
                  && in_ready_a === 1'b0);
        @(negedge clk);
        clr_ok &= (core_enable_a === 1'b0 && core_tdata_a === 1'b0 && in_ready_a === 1'b0);
        @(negedge clk);
        chk("clr_load enable low 2 cycles", 32'(clr_ok), 32'd1);
        bits = '0;
        shift_ok = 1'b1;
        for (int k = 0; k < 32; k++) begin
            bits[31-k] = core_tdata_a;
            shift_ok &= (core_enable_a === 1'b1 && in_ready_a === 1'b0
                         && core_tdata_b === core_tdata_a);
            if (k == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            @(negedge clk);
        end
        chk("shift enable high, in_ready low", 32'(shift_ok), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] bits;
        logic        ok;
        int          go_a, go_b, n;

        rst        = 1'b1;
        in_data    = 8'h00;
        in_valid   = 1'b0;
        resp_ready = 1'b0;
        core_armed = 1'b0;
        core_done  = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset outputs", 32'({core_enable_a, core_tdata_a, core_go_a, resp_valid_a,
                                  in_ready_a, busy_a}), 32'd0);
        chk("reset resp_data", 32'(resp_data_a), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // LOAD delay=0x1234 width=0x0005 polarity=0
        do_load(16'h1234, 16'h0005, 8'h00, -1, bits);
        chk("load1 serial bits", bits, 32'h12340005);
        chk("load1 tdata after shift", 32'(core_tdata_a), 32'd0);
        chk("load1 enable held", 32'(core_enable_a), 32'd1);
        core_armed = 1'b1;
        wait_resp(8'hA0, "load1 resp");

        // LOAD with polarity 1: t_data must hold 1 afterwards
        core_armed = 1'b0;
        do_load(16'hABCD, 16'h8001, 8'h01, -1, bits);
        chk("load2 serial bits", bits, 32'hABCD8001);
        core_armed = 1'b1;
        wait_resp(8'hA0, "load2 resp");
        ok = 1'b1;
        repeat (100) begin
            ok &= (core_tdata_a === 1'b1 && core_tdata_b === 1'b1);
            @(negedge clk);
        end
        chk("polarity held 100 cycles", 32'(ok), 32'd1);

        // FIRE: done comes 20 cycles after go; the short-timeout instance gives up at 10
        send_byte(8'h02);
        chk("fire go first cycle", 32'({core_go_a, core_go_b}), 32'd3);
        go_a = 0;
        go_b = 0;
        for (int c = 0; c < 60; c++) begin
            if (core_go_a === 1'b1) go_a++;
            if (core_go_b === 1'b1) go_b++;
            if (c == 20) core_done = 1'b1;
            @(negedge clk);
        end
        core_done = 1'b0;
        chk("fire go high cycles", 32'(go_a), 32'd21);
        chk("done timeout go high cycles", 32'(go_b), 32'd10);
        chk("done timeout resp", 32'({resp_valid_b, resp_data_b}), 32'h1E2);
        wait_resp(8'hA1, "fire resp");

        // FIRE while not armed
        core_armed = 1'b0;
        send_byte(8'h02);
        chk("unarmed fire no go", 32'({core_go_a, core_go_b}), 32'd0);
        wait_resp(8'hE3, "unarmed fire resp");

        // Unknown opcode
        send_byte(8'h7F);
        wait_resp(8'hE0, "bad opcode resp");

        // Arm timeout: armed stays low
        do_load(16'h0001, 16'h0002, 8'h00, -1, bits);
        chk("load3 serial bits", bits, 32'h00010002);
        n = 0;
        while (resp_valid_a !== 1'b1 && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("arm timeout wait cycles", 32'(n), 32'd8);
        chk("arm timeout enable stays", 32'(core_enable_a), 32'd1);
        wait_resp(8'hE1, "arm timeout resp");

        // Reset in shift cycle 10, then CLEAR with a stalled host
        do_load(16'hFFFF, 16'hFFFF, 8'h01, 10, bits);
        chk("mid-shift reset outputs", 32'({core_enable_a, core_tdata_a, core_go_a,
                                            resp_valid_a, in_ready_a, busy_a}), 32'd0);
        chk("mid-shift reset resp_data", 32'(resp_data_a), 32'd0);
        send_byte(8'h03);
        ok = (core_enable_a === 1'b0 && busy_a === 1'b1 && resp_valid_a === 1'b0);
        @(negedge clk);
        ok &= (core_enable_a === 1'b0 && resp_valid_a === 1'b0);
        @(negedge clk);
        chk("clear enable low 2 cycles", 32'(ok), 32'd1);
        ok = 1'b1;
        repeat (5) begin
            ok &= (resp_valid_a === 1'b1 && resp_data_a === 8'hA2 && in_ready_a === 1'b0);
            @(negedge clk);
        end
        chk("clear resp held while stalled", 32'(ok), 32'd1);
        wait_resp(8'hA2, "clear resp");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
